wb_to_obi_bridge: RTL and testbench



---
 rtl/wb_obi_pkg.sv | 23 ++
 rtl/wb_obi_timeout.sv | 39 +++
 rtl/wb_to_obi_bridge.sv | 157 +++++++++++++++
 tb/tb_wb_to_obi_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_obi_pkg.sv
// Shared types, constants and sizing helpers for the Wishbone-to-OBI bridge.
package wb_obi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned TIMEOUT_CNT_W          = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // A disabled timeout (0) still needs a legal one-bit counter width.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_obi_timeout.sv
// Saturating wait counter: clears on request, counts while enabled and
// flags expiry once the count has reached LIMIT.
module wb_obi_timeout
  import wb_obi_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W = TIMEOUT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT_C);

endmodule

// File: rtl/wb_to_obi_bridge.sv
// Wishbone classic responder that issues one OBI initiator transaction per
// transfer, tracking aborts and timing out so a dead target cannot hang the bus.
module wb_to_obi_bridge
  import wb_obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,
  output logic                    busy_o
);

  localparam int unsigned BE_W  = be_width(DATA_WIDTH);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic                  abort_q, abort_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  latch;
  logic                  aborting;
  logic                  tmo_clr, tmo_en, tmo_expired;

  // An abort seen in the current cycle counts just like one already recorded.
  assign aborting = abort_q | ~wb_cyc_i;

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d = ST_REQ;
          abort_d = 1'b0;
          latch   = 1'b1;
        end
      end
      ST_REQ: begin
        abort_d = aborting;
        if (obi_gnt_i) begin
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          state_d = aborting ? ST_IDLE : ST_DONE;
          err_d   = ~aborting;
          abort_d = 1'b0;
        end
      end
      ST_RESP: begin
        abort_d = aborting;
        if (obi_rvalid_i) begin
          abort_d = 1'b0;
          if (aborting) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            ack_d   = ~obi_err_i;
            err_d   = obi_err_i;
            if (!we_q) begin
              rdata_d = obi_rdata_i;
            end
          end
        end else if (tmo_expired) begin
          state_d = aborting ? ST_IDLE : ST_DONE;
          err_d   = ~aborting;
          abort_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (latch) begin
        addr_q  <= wb_addr_i;
        we_q    <= wb_we_i;
        be_q    <= wb_sel_i;
        wdata_q <= wb_data_i;
      end
    end
  end

  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q == ST_REQ) || (state_q == ST_RESP);

  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    assign tmo_expired = 1'b0;
  end else begin : g_timeout
    wb_obi_timeout #(
      .LIMIT(TIMEOUT_CYCLES),
      .CNT_W(CNT_W)
    ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expired_o(tmo_expired)
    );
  end

  assign wb_data_o   = rdata_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign obi_req_o   = (state_q == ST_REQ);
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_to_obi_bridge.sv
// Self-checking bench for wb_to_obi_bridge: a cycle table for read/write/error
// plus directed sequences for timeout, abort, reset and back-to-back reads.
module tb_wb_to_obi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, gnt, rvalid, oerr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;

  logic [31:0] dataO, obiAddr, obiWdata;
  logic        ack, err, req, obiWe, busy;
  logic [3:0]  obiBe;

  logic [31:0] dataOT, obiAddrT, obiWdataT;
  logic        ackT, errT, reqT, obiWeT, busyT;
  logic [3:0]  obiBeT;

  int total = 0;
  int bad   = 0;

  wb_to_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel), .wb_data_o(dataO),
    .wb_ack_o(ack), .wb_err_o(err), .obi_req_o(req), .obi_gnt_i(gnt),
    .obi_addr_o(obiAddr), .obi_we_o(obiWe), .obi_be_o(obiBe), .obi_wdata_o(obiWdata),
    .obi_rvalid_i(rvalid), .obi_rdata_i(rdata), .obi_err_i(oerr), .busy_o(busy)
  );

  wb_to_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dutT (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel), .wb_data_o(dataOT),
    .wb_ack_o(ackT), .wb_err_o(errT), .obi_req_o(reqT), .obi_gnt_i(gnt),
    .obi_addr_o(obiAddrT), .obi_we_o(obiWeT), .obi_be_o(obiBeT), .obi_wdata_o(obiWdataT),
    .obi_rvalid_i(rvalid), .obi_rdata_i(rdata), .obi_err_i(oerr), .busy_o(busyT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        oerr;
    logic        eReq, eAck, eErr, eBusy;
    logic [31:0] eData, eAddr;
    logic        eWe;
    logic [3:0]  eBe;
    logic [31:0] eWdata;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic s, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] sl, input logic g,
                               input logic rv, input logic [31:0] rd, input logic oe);
    cyc = c; stb = s; we = w; addr = a; wdata = wd; sel = sl;
    gnt = g; rvalid = rv; rdata = rd; oerr = oe;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyIdle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkMain(input string tag, input logic eReq, input logic eAck, input logic eErr,
                           input logic eBusy, input logic [31:0] eData);
    checkOutput({tag, ".req"},  {31'b0, req},  {31'b0, eReq});
    checkOutput({tag, ".ack"},  {31'b0, ack},  {31'b0, eAck});
    checkOutput({tag, ".err"},  {31'b0, err},  {31'b0, eErr});
    checkOutput({tag, ".busy"}, {31'b0, busy}, {31'b0, eBusy});
    checkOutput({tag, ".data"}, dataO, eData);
  endtask

  task automatic checkTo(input string tag, input logic eReq, input logic eAck, input logic eErr,
                         input logic eBusy, input logic [31:0] eData);
    checkOutput({tag, ".req"},  {31'b0, reqT},  {31'b0, eReq});
    checkOutput({tag, ".ack"},  {31'b0, ackT},  {31'b0, eAck});
    checkOutput({tag, ".err"},  {31'b0, errT},  {31'b0, eErr});
    checkOutput({tag, ".busy"}, {31'b0, busyT}, {31'b0, eBusy});
    checkOutput({tag, ".data"}, dataOT, eData);
  endtask

  task automatic setIn(input int i, input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sl, input logic g, input logic rv,
                       input logic [31:0] rd, input logic oe);
    vecs[i].cyc = c; vecs[i].stb = s; vecs[i].we = w; vecs[i].addr = a; vecs[i].wdata = wd;
    vecs[i].sel = sl; vecs[i].gnt = g; vecs[i].rvalid = rv; vecs[i].rdata = rd; vecs[i].oerr = oe;
  endtask

  task automatic setExp(input int i, input logic rq, input logic ak, input logic er, input logic bz,
                        input logic [31:0] d, input logic [31:0] a, input logic w, input logic [3:0] be,
                        input logic [31:0] wd);
    vecs[i].eReq = rq; vecs[i].eAck = ak; vecs[i].eErr = er; vecs[i].eBusy = bz;
    vecs[i].eData = d; vecs[i].eAddr = a; vecs[i].eWe = w; vecs[i].eBe = be; vecs[i].eWdata = wd;
  endtask

  initial begin
    // Row i: expected outputs during cycle i, then inputs driven for cycle i.
    setIn(0,  1,1,0,32'h100,32'h0,4'hF,0,0,32'h0,0);              setExp(0,  0,0,0,0,32'h0,32'h0,0,4'h0,32'h0);
    setIn(1,  1,1,0,32'h100,32'h0,4'hF,1,0,32'h0,0);              setExp(1,  1,0,0,1,32'h0,32'h100,0,4'hF,32'h0);
    setIn(2,  1,1,0,32'h100,32'h0,4'hF,0,1,32'hDEADBEEF,0);       setExp(2,  0,0,0,1,32'h0,32'h100,0,4'hF,32'h0);
    setIn(3,  0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0);                setExp(3,  0,1,0,1,32'hDEADBEEF,32'h100,0,4'hF,32'h0);
    setIn(4,  1,1,1,32'h204,32'h12345678,4'h3,0,0,32'h0,0);       setExp(4,  0,0,0,0,32'hDEADBEEF,32'h100,0,4'hF,32'h0);
    setIn(5,  1,1,1,32'h204,32'h12345678,4'h3,0,0,32'h0,0);       setExp(5,  1,0,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(6,  1,1,1,32'h204,32'h12345678,4'h3,0,0,32'h0,0);       setExp(6,  1,0,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(7,  1,1,1,32'h204,32'h12345678,4'h3,0,0,32'h0,0);       setExp(7,  1,0,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(8,  1,1,1,32'h204,32'h12345678,4'h3,1,0,32'h0,0);       setExp(8,  1,0,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(9,  1,1,1,32'h204,32'h12345678,4'h3,0,1,32'hCAFEF00D,0); setExp(9,  0,0,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(10, 0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0);                setExp(10, 0,1,0,1,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(11, 1,1,0,32'h300,32'h0,4'hF,0,0,32'h0,0);              setExp(11, 0,0,0,0,32'hDEADBEEF,32'h204,1,4'h3,32'h12345678);
    setIn(12, 1,1,0,32'h300,32'h0,4'hF,1,0,32'h0,0);              setExp(12, 1,0,0,1,32'hDEADBEEF,32'h300,0,4'hF,32'h0);
    setIn(13, 1,1,0,32'h300,32'h0,4'hF,0,0,32'h0,0);              setExp(13, 0,0,0,1,32'hDEADBEEF,32'h300,0,4'hF,32'h0);
    setIn(14, 1,1,0,32'h300,32'h0,4'hF,0,1,32'hDEADBEEF,1);       setExp(14, 0,0,0,1,32'hDEADBEEF,32'h300,0,4'hF,32'h0);
    setIn(15, 0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0);                setExp(15, 0,0,1,1,32'hDEADBEEF,32'h300,0,4'hF,32'h0);
    setIn(16, 0,0,0,32'h0,32'h0,4'h0,0,0,32'h0,0);                setExp(16, 0,0,0,0,32'hDEADBEEF,32'h300,0,4'hF,32'h0);

    doReset();
    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      checkMain(tag, vecs[i].eReq, vecs[i].eAck, vecs[i].eErr, vecs[i].eBusy, vecs[i].eData);
      checkOutput({tag, ".addr"},  obiAddr, vecs[i].eAddr);
      checkOutput({tag, ".we"},    {31'b0, obiWe}, {31'b0, vecs[i].eWe});
      checkOutput({tag, ".be"},    {28'b0, obiBe}, {28'b0, vecs[i].eBe});
      checkOutput({tag, ".wdata"}, obiWdata, vecs[i].eWdata);
      applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel,
                    vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].oerr);
      tick();
    end

    // Timeout with limit 4: REQ holds counts 0..4, error shows in the following cycle.
    doReset();
    applyStimulus(1,1,0,32'h400,32'h0,4'hF,0,0,32'h0,0);
    tick();
    for (int c = 1; c <= 5; c++) begin
      checkTo($sformatf("to_req%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      tick();
    end
    checkTo("to_expire", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    applyIdle();
    tick();
    checkTo("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(0,0,0,32'h0,32'h0,4'h0,0,1,32'h55AA55AA,0);
    tick();
    checkTo("to_stray1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyIdle();
    tick();
    checkTo("to_stray2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Abort: a completed read first, then cyc drops in RESP and rvalid comes 5 cycles later.
    doReset();
    applyStimulus(1,1,0,32'h500,32'h0,4'hF,0,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h500,32'h0,4'hF,1,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h500,32'h0,4'hF,0,1,32'h600DF00D,0);
    tick();
    checkMain("ab_first", 1'b0, 1'b1, 1'b0, 1'b1, 32'h600DF00D);
    applyIdle();
    tick();
    applyStimulus(1,1,0,32'h504,32'h0,4'hF,0,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h504,32'h0,4'hF,1,0,32'h0,0);
    tick();
    applyIdle();
    tick();
    for (int c = 7; c <= 11; c++) begin
      checkMain($sformatf("ab_wait%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 32'h600DF00D);
      if (c == 11) applyStimulus(0,0,0,32'h0,32'h0,4'h0,0,1,32'hBAD0BAD0,0);
      tick();
    end
    checkMain("ab_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h600DF00D);
    applyIdle();
    tick();
    checkMain("ab_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h600DF00D);

    // Reset asserted while waiting in RESP clears outputs without a clock edge.
    doReset();
    applyStimulus(1,1,0,32'h700,32'h0,4'hF,0,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h700,32'h0,4'hF,1,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h700,32'h0,4'hF,0,1,32'h12121212,0);
    tick();
    checkMain("rs_first", 1'b0, 1'b1, 1'b0, 1'b1, 32'h12121212);
    applyIdle();
    tick();
    applyStimulus(1,1,0,32'h704,32'h0,4'hF,0,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h704,32'h0,4'hF,1,0,32'h0,0);
    tick();
    checkMain("rs_resp", 1'b0, 1'b0, 1'b0, 1'b1, 32'h12121212);
    rst = 1'b1;
    #1;
    checkMain("rs_async", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rs_async.addr", obiAddr, 32'h0);
    checkOutput("rs_async.be", {28'b0, obiBe}, 32'h0);
    applyIdle();
    tick();
    rst = 1'b0;
    applyStimulus(0,0,0,32'h0,32'h0,4'h0,0,1,32'h34343434,0);
    tick();
    checkMain("rs_late_rv", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyIdle();
    tick();
    checkMain("rs_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back reads with stb held high across the first ack.
    doReset();
    applyStimulus(1,1,0,32'h10,32'h0,4'hF,0,0,32'h0,0);
    tick();
    checkMain("bb_req1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1,1,0,32'h10,32'h0,4'hF,1,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h10,32'h0,4'hF,0,1,32'hAAAA5555,0);
    tick();
    checkMain("bb_ack1", 1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA5555);
    applyStimulus(1,1,0,32'h14,32'h0,4'hF,0,0,32'h0,0);
    tick();
    checkOutput("bb_gap.ack", {31'b0, ack}, 32'h0);
    checkOutput("bb_gap.data", dataO, 32'hAAAA5555);
    tick();
    checkOutput("bb_req2.req", {31'b0, req}, 32'h1);
    checkOutput("bb_req2.addr", obiAddr, 32'h14);
    applyStimulus(1,1,0,32'h14,32'h0,4'hF,1,0,32'h0,0);
    tick();
    applyStimulus(1,1,0,32'h14,32'h0,4'hF,0,1,32'h0BADCAFE,0);
    tick();
    checkMain("bb_ack2", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BADCAFE);
    applyIdle();
    tick();
    checkMain("bb_end", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BADCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
